// File: rtl/herloa_if.sv
`default_nettype none
// ============================================================================
//  Module   : herloa_if
//  Purpose  : Operand/result bundle for the herloa approximate adder.
//  Revision : 1.0  initial release
// ============================================================================
interface herloa_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] S;
    logic         out_valid;

    modport master (
        output in_valid,
        output A,
        output B,
        input  S,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output S,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/herloa.sv
`default_nettype none
// ============================================================================
//  Module   : herloa
//  Purpose  : N-bit hybrid error-reduction lower-part OR adder, registered out.
//  Revision : 1.0  initial release
// ============================================================================
module herloa #(
    parameter int N = 16,
    parameter int K = 10
) (
    input  logic     clk,
    input  logic     rst,
    herloa_if.slave  bus
);

    generate
        if (K < 2 || K > N - 1) begin : g_bad_k
            $error("herloa: K must satisfy 2 <= K <= N-1");
        end
    endgenerate

    logic           w_c_up;
    logic           w_f;
    logic [K-1:0]   w_low;
    logic [N-K-1:0] w_cup_ext;
    logic [N-K-1:0] w_up;
    logic [N-1:0]   w_sum;

    logic [N-1:0]   r_sum;
    logic           r_valid;

    // Top two approximate positions feed the exact part and the error fix-up.
    assign w_c_up    = bus.A[K-1] & bus.B[K-1];
    assign w_f       = bus.A[K-2] & bus.B[K-2];
    assign w_cup_ext = (N-K)'(w_c_up);

    assign w_low[K-1]   = (bus.A[K-1] ^ bus.B[K-1]) | w_f;
    assign w_low[K-2:0] = bus.A[K-2:0] | bus.B[K-2:0] | {(K-1){w_f}};

    // Exact upper part; the carry out of the MSB falls off the top.
    assign w_up  = bus.A[N-1:K] + bus.B[N-1:K] + w_cup_ext;
    assign w_sum = {w_up, w_low};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum <= w_sum;
            end
        end
    end

    assign bus.S         = r_sum;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_herloa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_herloa
//  Purpose  : Scoreboard bench for herloa at (16,10), (16,4) and (8,2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_herloa;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;

    int checks;
    int errors;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    herloa_if #(.N(16)) bus0 ();
    herloa_if #(.N(16)) bus1 ();
    herloa_if #(.N(8))  bus2 ();

    assign bus0.in_valid = in_valid;
    assign bus0.A        = a;
    assign bus0.B        = b;
    assign bus1.in_valid = in_valid;
    assign bus1.A        = a;
    assign bus1.B        = b;
    assign bus2.in_valid = in_valid;
    assign bus2.A        = a[7:0];
    assign bus2.B        = b[7:0];

    herloa #(.N(16), .K(10)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    herloa #(.N(16), .K(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
    herloa #(.N(8),  .K(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit reference of the approximate adder rules.
    function automatic logic [15:0] ref_sum(input int n, input int k,
                                            input logic [15:0] av,
                                            input logic [15:0] bv);
        logic [15:0] s;
        logic        f;
        logic        cup;
        int unsigned up;
        int unsigned ua;
        int unsigned ub;
        s   = '0;
        f   = av[k-2] & bv[k-2];
        cup = av[k-1] & bv[k-1];
        for (int i = 0; i < k - 1; i++) s[i] = av[i] | bv[i] | f;
        s[k-1] = (av[k-1] ^ bv[k-1]) | f;
        ua = (32'(av) & ((32'd1 << n) - 1)) >> k;
        ub = (32'(bv) & ((32'd1 << n) - 1)) >> k;
        up = (ua + ub + 32'(cup)) & ((32'd1 << (n - k)) - 1);
        s  = s | 16'(up << k);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] exp0);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        q0.push_back(exp0);
        q1.push_back(ref_sum(16, 4, av, bv));
        q2.push_back(ref_sum(8, 2, av & 16'h00FF, bv & 16'h00FF));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a result is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.out_valid) begin
                if (q0.size() == 0) chk("k10_unexpected_valid", 16'h1, 16'h0);
                else                chk("k10_sum", bus0.S, q0.pop_front());
            end
            if (bus1.out_valid) begin
                if (q1.size() == 0) chk("k4_unexpected_valid", 16'h1, 16'h0);
                else                chk("k4_sum", bus1.S, q1.pop_front());
            end
            if (bus2.out_valid) begin
                if (q2.size() == 0) chk("n8k2_unexpected_valid", 16'h1, 16'h0);
                else                chk("n8k2_sum", {8'h00, bus2.S}, q2.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] av;
        logic [15:0] bv;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #2;
        chk("reset_S", bus0.S, 16'h0000);
        chk("reset_out_valid", {15'h0, bus0.out_valid}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, expectations worked by hand for N=16, K=10.
        issue(16'h0000, 16'h0000, 16'h0000);
        issue(16'h00FF, 16'h00FF, 16'h00FF);
        issue(16'hFF00, 16'hFF00, 16'hFFFF);
        issue(16'hFFFF, 16'h0001, 16'hFFFF);
        issue(16'hAAAA, 16'h5555, 16'hFFFF);
        issue(16'h0001, 16'h0001, 16'h0001);
        issue(16'h0100, 16'h0100, 16'h03FF);
        issue(16'h0200, 16'h0200, 16'h0400);
        issue(16'hFFFF, 16'hFFFF, 16'hFFFF);
        idle();
        chk("hold_out_valid", {15'h0, bus0.out_valid}, 16'h0000);
        chk("hold_S", bus0.S, 16'hFFFF);
        idle();
        chk("hold_S_2", bus0.S, 16'hFFFF);

        // Asynchronous reset between edges while S is nonzero.
        issue(16'h0400, 16'h0400, 16'h0800);
        idle();
        chk("pre_reset_S", bus0.S, 16'h0800);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_S", bus0.S, 16'h0000);
        chk("async_rst_out_valid", {15'h0, bus0.out_valid}, 16'h0000);
        chk("async_rst_S_k4", bus1.S, 16'h0000);
        chk("async_rst_S_n8", {8'h00, bus2.S}, 16'h0000);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        @(posedge clk);
        #1;
        chk("in_reset_out_valid", {15'h0, bus0.out_valid}, 16'h0000);
        chk("in_reset_S", bus0.S, 16'h0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        chk("post_release_out_valid", {15'h0, bus0.out_valid}, 16'h0000);
        chk("post_release_S", bus0.S, 16'h0000);

        // Randomized sweep against the reference model.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(9) == 0) begin
                idle();
            end else begin
                av = 16'($urandom);
                bv = 16'($urandom);
                issue(av, bv, ref_sum(16, 10, av, bv));
            end
        end
        idle();
        idle();
        idle();
        chk("drain_q0", 16'(q0.size()), 16'h0000);
        chk("drain_q1", 16'(q1.size()), 16'h0000);
        chk("drain_q2", 16'(q2.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
